// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs,
// ALU operations, mux selects and the bundled control word.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ALU_CLS_ADD   = 2'd0,
        ALU_CLS_SUB   = 2'd1,
        ALU_CLS_FUNCT = 2'd2
    } alu_cls_t;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_op;
        logic       illegal_op;
    } ctl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction fields and memory handshake in,
// per-cycle enables and mux selects out.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [3:0] ALU_op;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               ALU_op, illegal_op, state_dbg
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
               ALU_op, illegal_op, state_dbg
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU control: fixed add/sub, or funct-driven for R-type.
// Unknown funct falls back to add and raises bad_funct.
module alu_decoder
    import mc_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       bad_funct
);
    always_comb begin
        alu_op    = ALU_ADD;
        bad_funct = 1'b0;
        case (cls)
            ALU_CLS_SUB: alu_op = ALU_SUB;
            ALU_CLS_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_NOR:  alu_op = ALU_NOR;
                    default: bad_funct = 1'b1;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// Moore controller for the multicycle MIPS datapath. Outputs decode from the
// state (plus mem_ready in FETCH) and are all forced low while rst is low.
module multicycle_control
    import mc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    state_t     state;
    state_t     next;
    alu_cls_t   alu_cls;
    logic [3:0] alu_op_dec;
    logic       bad_funct;
    logic       alu_en;
    ctl_t       ctl;
    ctl_t       ctl_out;

    always_ff @(posedge clk) begin
        if (!rst) state <= FETCH;
        else      state <= next;
    end

    // Kept apart from the main decode so the decoder sits outside any comb loop.
    always_comb begin
        alu_cls = ALU_CLS_ADD;
        case (state)
            RTYPE_EX: alu_cls = ALU_CLS_FUNCT;
            BRANCH:   alu_cls = ALU_CLS_SUB;
            default:  alu_cls = ALU_CLS_ADD;
        endcase
    end

    alu_decoder u_alu_dec (
        .cls       (alu_cls),
        .funct     (bus.funct),
        .alu_op    (alu_op_dec),
        .bad_funct (bad_funct)
    );

    always_comb begin
        next   = FETCH;
        ctl    = '0;
        alu_en = 1'b0;
        case (state)
            FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.pc_source = PCSRC_ALU;
                ctl.ir_write  = bus.mem_ready;
                ctl.pc_write  = bus.mem_ready;
                alu_en        = 1'b1;
                next          = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ctl.alu_src_b = SRCB_IMM_SH2;
                alu_en        = 1'b1;
                case (bus.opcode)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_RTYPE:     next = RTYPE_EX;
                    OP_BEQ:       next = BRANCH;
                    OP_J:         next = JUMP;
                    OP_ADDI:      next = ADDI_EX;
                    default: begin
                        ctl.illegal_op = 1'b1;
                        next           = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                alu_en        = 1'b1;
                if (bus.opcode == OP_SW)      next = MEMWR;
                else if (bus.opcode == OP_LW) next = MEMRD;
                else                          next = FETCH;
            end
            MEMRD: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                next         = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                next           = FETCH;
            end
            MEMWR: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
                next          = bus.mem_ready ? FETCH : MEMWR;
            end
            RTYPE_EX: begin
                ctl.alu_src_a  = 1'b1;
                ctl.alu_src_b  = SRCB_RT;
                ctl.illegal_op = bad_funct;
                alu_en         = 1'b1;
                next           = RTYPE_WB;
            end
            RTYPE_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                next          = FETCH;
            end
            BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRCB_RT;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
                alu_en            = 1'b1;
                next              = FETCH;
            end
            JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JUMP;
                next          = FETCH;
            end
            ADDI_EX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                alu_en        = 1'b1;
                next          = ADDI_WB;
            end
            ADDI_WB: begin
                ctl.reg_write = 1'b1;
                next          = FETCH;
            end
            default: next = FETCH;
        endcase
        // ALU_op is only meaningful in states that actually use the ALU.
        ctl.alu_op = alu_en ? alu_op_dec : 4'b0000;
    end

    assign ctl_out = rst ? ctl : '0;

    assign bus.PCWrite     = ctl_out.pc_write;
    assign bus.PCWriteCond = ctl_out.pc_write_cond;
    assign bus.IorD        = ctl_out.i_or_d;
    assign bus.MemRead     = ctl_out.mem_read;
    assign bus.MemWrite    = ctl_out.mem_write;
    assign bus.IRWrite     = ctl_out.ir_write;
    assign bus.MemtoReg    = ctl_out.mem_to_reg;
    assign bus.RegDst      = ctl_out.reg_dst;
    assign bus.RegWrite    = ctl_out.reg_write;
    assign bus.ALUSrcA     = ctl_out.alu_src_a;
    assign bus.ALUSrcB     = ctl_out.alu_src_b;
    assign bus.PCSource    = ctl_out.pc_source;
    assign bus.ALU_op      = ctl_out.alu_op;
    assign bus.illegal_op  = ctl_out.illegal_op;
    assign bus.state_dbg   = rst ? state : 4'd0;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and control-word checks
// against hand-written expected words for each instruction class.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    multicycle_control_if bus();
    multicycle_control dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,PCSource,ALU_op,illegal_op}
    logic [18:0] ctl;
    assign ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                  bus.ALUSrcB, bus.PCSource, bus.ALU_op, bus.illegal_op};

    localparam logic [18:0] E_ZERO    = 19'b0_0_0_0_0_0_0_0_0_0_00_00_0000_0;
    localparam logic [18:0] E_FETCH_R = 19'b1_0_0_1_0_1_0_0_0_0_01_00_0010_0;
    localparam logic [18:0] E_FETCH_W = 19'b0_0_0_1_0_0_0_0_0_0_01_00_0010_0;
    localparam logic [18:0] E_DEC     = 19'b0_0_0_0_0_0_0_0_0_0_11_00_0010_0;
    localparam logic [18:0] E_DEC_ILL = 19'b0_0_0_0_0_0_0_0_0_0_11_00_0010_1;
    localparam logic [18:0] E_MEMADR  = 19'b0_0_0_0_0_0_0_0_0_1_10_00_0010_0;
    localparam logic [18:0] E_MEMRD   = 19'b0_0_1_1_0_0_0_0_0_0_00_00_0000_0;
    localparam logic [18:0] E_MEMWB   = 19'b0_0_0_0_0_0_1_0_1_0_00_00_0000_0;
    localparam logic [18:0] E_MEMWR   = 19'b0_0_1_0_1_0_0_0_0_0_00_00_0000_0;
    localparam logic [18:0] E_RTWB    = 19'b0_0_0_0_0_0_0_1_1_0_00_00_0000_0;
    localparam logic [18:0] E_BR      = 19'b0_1_0_0_0_0_0_0_0_1_00_01_0110_0;
    localparam logic [18:0] E_JMP     = 19'b1_0_0_0_0_0_0_0_0_0_00_10_0000_0;
    localparam logic [18:0] E_ADDIEX  = 19'b0_0_0_0_0_0_0_0_0_1_10_00_0010_0;
    localparam logic [18:0] E_ADDIWB  = 19'b0_0_0_0_0_0_0_0_1_0_00_00_0000_0;

    task automatic settle(input logic rdy, input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        bus.mem_ready = rdy;
        bus.opcode    = op;
        bus.funct     = fn;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            settle(1'b1, 6'b100011, 6'd0);
            nvec++;
            if ({bus.state_dbg, ctl} !== {4'd0, E_ZERO}) begin
                nerr++;
                $display("FAIL reset cyc%0d: got st=%0d ctl=%b want st=0 ctl=%b", i, bus.state_dbg, ctl, E_ZERO);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        nvec++;
        if ({bus.state_dbg, bus.MemRead, ctl} !== {4'd0, 1'b1, E_FETCH_R}) begin
            nerr++;
            $display("FAIL reset_release: got st=%0d ctl=%b want st=0 ctl=%b", bus.state_dbg, ctl, E_FETCH_R);
        end
        bus.mem_ready = 1'b0;
        #1;
        nvec++;
        if ({bus.state_dbg, ctl} !== {4'd0, E_FETCH_W}) begin
            nerr++;
            $display("FAIL reset_fetch_wait: got st=%0d ctl=%b want st=0 ctl=%b", bus.state_dbg, ctl, E_FETCH_W);
        end
    endtask

    task automatic test_lw();
        logic [18:0] ew[5];
        logic [3:0]  es[5];
        ew = '{E_FETCH_R, E_DEC, E_MEMADR, E_MEMRD, E_MEMWB};
        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        for (int i = 0; i < 5; i++) begin
            settle(1'b1, 6'b100011, 6'd0);
            nvec++;
            if ({bus.state_dbg, ctl} !== {es[i], ew[i]}) begin
                nerr++;
                $display("FAIL lw cyc%0d: got st=%0d ctl=%b want st=%0d ctl=%b", i, bus.state_dbg, ctl, es[i], ew[i]);
            end
        end
    endtask

    task automatic test_fetch_stall();
        logic [18:0] ew[7];
        logic [3:0]  es[7];
        logic        rd[7];
        int          npcw = 0;
        int          nmw  = 0;
        ew = '{E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DEC, E_MEMADR, E_MEMWR, E_MEMWR};
        es = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
        rd = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            settle(rd[i], 6'b101011, 6'd0);
            if (bus.PCWrite)  npcw++;
            if (bus.MemWrite) nmw++;
            nvec++;
            if ({bus.state_dbg, ctl} !== {es[i], ew[i]}) begin
                nerr++;
                $display("FAIL sw_stall cyc%0d: got st=%0d ctl=%b want st=%0d ctl=%b", i, bus.state_dbg, ctl, es[i], ew[i]);
            end
        end
        nvec++;
        if (npcw !== 1) begin
            nerr++;
            $display("FAIL sw_stall_pcwrite_count: got %0d want 1", npcw);
        end
        nvec++;
        if (nmw !== 2) begin
            nerr++;
            $display("FAIL sw_stall_memwrite_count: got %0d want 2", nmw);
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn[7];
        logic [3:0]  op[7];
        logic [18:0] ew[4];
        logic [3:0]  es[4];
        fn = '{6'b101010, 6'b111111, 6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111};
        op = '{4'b0111,   4'b0010,   4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b1100};
        es = '{4'd0, 4'd1, 4'd6, 4'd7};
        for (int k = 0; k < 7; k++) begin
            ew = '{E_FETCH_R, E_DEC, {10'b0000000001, 2'b00, 2'b00, op[k], (k == 1)}, E_RTWB};
            for (int i = 0; i < 4; i++) begin
                settle(1'b1, 6'b000000, fn[k]);
                nvec++;
                if ({bus.state_dbg, ctl} !== {es[i], ew[i]}) begin
                    nerr++;
                    $display("FAIL rtype fn=%b cyc%0d: got st=%0d ctl=%b want st=%0d ctl=%b", fn[k], i, bus.state_dbg, ctl, es[i], ew[i]);
                end
            end
        end
    endtask

    task automatic test_addi();
        logic [18:0] ew[4];
        logic [3:0]  es[4];
        ew = '{E_FETCH_R, E_DEC, E_ADDIEX, E_ADDIWB};
        es = '{4'd0, 4'd1, 4'd10, 4'd11};
        for (int i = 0; i < 4; i++) begin
            settle(1'b1, 6'b001000, 6'd0);
            nvec++;
            if ({bus.state_dbg, ctl} !== {es[i], ew[i]}) begin
                nerr++;
                $display("FAIL addi cyc%0d: got st=%0d ctl=%b want st=%0d ctl=%b", i, bus.state_dbg, ctl, es[i], ew[i]);
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [18:0] ew[6];
        logic [3:0]  es[6];
        logic        rd[6];
        logic [5:0]  oc[6];
        // mem_ready low in DECODE/BRANCH must not stall anything
        ew = '{E_FETCH_R, E_DEC, E_BR, E_FETCH_R, E_DEC, E_JMP};
        es = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9};
        rd = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        oc = '{6'b000100, 6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010};
        for (int i = 0; i < 6; i++) begin
            settle(rd[i], oc[i], 6'd0);
            nvec++;
            if ({bus.state_dbg, ctl} !== {es[i], ew[i]}) begin
                nerr++;
                $display("FAIL beq_j cyc%0d: got st=%0d ctl=%b want st=%0d ctl=%b", i, bus.state_dbg, ctl, es[i], ew[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [18:0] ew[3];
        logic [3:0]  es[3];
        ew = '{E_FETCH_R, E_DEC_ILL, E_FETCH_W};
        es = '{4'd0, 4'd1, 4'd0};
        for (int i = 0; i < 3; i++) begin
            settle(i != 2, 6'b111111, 6'd0);
            nvec++;
            if ({bus.state_dbg, ctl} !== {es[i], ew[i]}) begin
                nerr++;
                $display("FAIL illegal_op cyc%0d: got st=%0d ctl=%b want st=%0d ctl=%b", i, bus.state_dbg, ctl, es[i], ew[i]);
            end
        end
    endtask

    task automatic test_reset_midwrite();
        logic [18:0] ew[4];
        logic [3:0]  es[4];
        // the FETCH stalled by the previous test completes here
        ew = '{E_FETCH_R, E_DEC, E_MEMADR, E_MEMWR};
        es = '{4'd0, 4'd1, 4'd2, 4'd5};
        for (int i = 0; i < 4; i++) begin
            settle(i != 3, 6'b101011, 6'd0);
            nvec++;
            if ({bus.state_dbg, ctl} !== {es[i], ew[i]}) begin
                nerr++;
                $display("FAIL rst_memwr cyc%0d: got st=%0d ctl=%b want st=%0d ctl=%b", i, bus.state_dbg, ctl, es[i], ew[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if ({bus.state_dbg, ctl} !== {4'd0, E_ZERO}) begin
            nerr++;
            $display("FAIL rst_memwr_drop: got st=%0d ctl=%b want st=0 ctl=%b", bus.state_dbg, ctl, E_ZERO);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        nvec++;
        if ({bus.state_dbg, ctl} !== {4'd0, E_FETCH_W}) begin
            nerr++;
            $display("FAIL rst_memwr_refetch: got st=%0d ctl=%b want st=0 ctl=%b", bus.state_dbg, ctl, E_FETCH_W);
        end
    endtask

    initial begin
        bus.opcode    = 6'b100011;
        bus.funct     = 6'd0;
        bus.mem_ready = 1'b1;
        test_reset();
        test_lw();
        test_fetch_stall();
        test_rtype();
        test_addi();
        test_branch_jump();
        test_illegal();
        test_reset_midwrite();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
